// File: rtl/pid_wr_pkg.sv
// Shared definitions for the PID pipeline configuration write sequencer.
// Holds the host/bus widths, the assembler state encoding, the number of
// data words per command and the layout of a queued command entry.
package pid_wr_pkg;

   localparam int W_HOST    = 16;
   localparam int W_WR_ADDR = 16;
   localparam int W_WR_CHAN = 16;
   localparam int W_WR_DATA = 48;

   localparam int N_DW = W_WR_DATA / W_HOST;
   localparam int W_DW = (N_DW > 1) ? $clog2(N_DW) : 1;
   localparam logic [W_DW-1:0] DW_LAST = W_DW'(N_DW - 1);

   // Entry layout, MSB to LSB: {addr, chan, data}
   localparam int W_ENTRY  = W_WR_ADDR + W_WR_CHAN + W_WR_DATA;
   localparam int OFS_DATA = 0;
   localparam int OFS_CHAN = OFS_DATA + W_WR_DATA;
   localparam int OFS_ADDR = OFS_CHAN + W_WR_CHAN;

   typedef enum logic [1:0] {
      S_ADDR = 2'd0,
      S_CHAN = 2'd1,
      S_DATA = 2'd2
   } asm_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset.
// Ports: clk_in/rst_in; push/din write side; pop/dout read side (dout shows
// the head entry combinationally); full/empty/count status.
// Push while full and pop while empty are ignored.
module sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int W_PTR = $clog2(DEPTH),
   localparam int W_CNT = W_PTR + 1
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [W_CNT-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [W_PTR-1:0] wr_ptr;
   logic [W_PTR-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == W_CNT'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Storage carries no reset; pointers and count define what is valid.
   always_ff @(posedge clk_in) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/pid_wr_sequencer.sv
// Host-side write initiator for the PID pipeline configuration bus.
// Assembles 16-bit host words into {addr, chan, data} commands, queues them,
// and issues one-cycle wr_en strobes when the pipeline is not holding.
// Ports: clk_in/rst_in (sync, active high); host_valid/host_sof/host_word/
// host_ready host stream; hold_in pipeline busy; wr_en/wr_addr/wr_chan/wr_data
// write bus; fifo_count pending commands; frame_err/clr_err sticky error.
//
// state  | meaning
// S_ADDR | waiting for a sof word carrying the address
// S_CHAN | next word is the channel
// S_DATA | collecting data words, MSW first, dw_cnt = word index
module pid_wr_sequencer
   import pid_wr_pkg::*;
#(
   parameter  int FIFO_DEPTH = 4,
   localparam int W_CNT      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 host_valid,
   input  logic                 host_sof,
   input  logic [W_HOST-1:0]    host_word,
   output logic                 host_ready,
   input  logic                 hold_in,
   output logic                 wr_en,
   output logic [W_WR_ADDR-1:0] wr_addr,
   output logic [W_WR_CHAN-1:0] wr_chan,
   output logic [W_WR_DATA-1:0] wr_data,
   output logic [W_CNT-1:0]     fifo_count,
   output logic                 frame_err,
   input  logic                 clr_err
);

   asm_state_t           state;
   logic [W_DW-1:0]      dw_cnt;
   logic [W_WR_ADDR-1:0] addr_q;
   logic [W_WR_CHAN-1:0] chan_q;
   logic [W_WR_DATA-1:0] data_q;
   logic [W_WR_DATA-1:0] data_nxt;

   logic               accept;
   logic               last_dw;
   logic               push;
   logic               pop;
   logic               err_set;
   logic               fifo_full;
   logic               fifo_empty;
   logic [W_ENTRY-1:0] fifo_dout;

   assign last_dw = (state == S_DATA) && (dw_cnt == DW_LAST);
   // The same-cycle pop is deliberately ignored so a push never meets a full FIFO.
   assign host_ready = !rst_in && !(last_dw && fifo_full);
   assign accept     = host_valid && host_ready;
   // Shifting in MSW first leaves word 0 in the top slice after N_DW words.
   assign data_nxt   = {data_q[W_WR_DATA-W_HOST-1:0], host_word};
   assign push       = accept && !host_sof && last_dw;
   assign pop        = !fifo_empty && !hold_in;
   assign err_set    = accept && (host_sof ? (state != S_ADDR) : (state == S_ADDR));

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state     <= S_ADDR;
         dw_cnt    <= '0;
         addr_q    <= '0;
         chan_q    <= '0;
         data_q    <= '0;
         frame_err <= 1'b0;
      end else begin
         if (accept) begin
            if (host_sof) begin
               addr_q <= host_word;
               state  <= S_CHAN;
            end else begin
               case (state)
                  S_ADDR: state <= S_ADDR;
                  S_CHAN: begin
                     chan_q <= host_word;
                     dw_cnt <= '0;
                     state  <= S_DATA;
                  end
                  S_DATA: begin
                     data_q <= data_nxt;
                     if (dw_cnt == DW_LAST) state <= S_ADDR;
                     else                   dw_cnt <= dw_cnt + 1'b1;
                  end
                  default: state <= S_ADDR;
               endcase
            end
         end
         if (clr_err)      frame_err <= 1'b0;
         else if (err_set) frame_err <= 1'b1;
      end
   end

   sync_fifo #(
      .WIDTH (W_ENTRY),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .push   (push),
      .din    ({addr_q, chan_q, data_nxt}),
      .pop    (pop),
      .dout   (fifo_dout),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (fifo_count)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_chan <= '0;
         wr_data <= '0;
      end else begin
         wr_en <= pop;
         if (pop) begin
            wr_addr <= fifo_dout[OFS_ADDR +: W_WR_ADDR];
            wr_chan <= fifo_dout[OFS_CHAN +: W_WR_CHAN];
            wr_data <= fifo_dout[OFS_DATA +: W_WR_DATA];
         end
      end
   end

endmodule

// File: tb/tb_pid_wr_sequencer.sv
// Self-checking bench for pid_wr_sequencer. Expected writes go into a
// scoreboard queue as frames are sent; a negedge monitor pops and compares
// on every wr_en. Scenario tasks add their own inline checks.
module tb_pid_wr_sequencer;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        host_valid;
   logic        host_sof;
   logic [15:0] host_word;
   logic        host_ready;
   logic        hold_in;
   logic        wr_en;
   logic [15:0] wr_addr;
   logic [15:0] wr_chan;
   logic [47:0] wr_data;
   logic [2:0]  fifo_count;
   logic        frame_err;
   logic        clr_err;

   int n_checks = 0;
   int n_fail   = 0;
   int n_writes = 0;
   int run_len  = 0;
   int max_run  = 0;

   logic [79:0] sb [$];

   always #5 clk_in = ~clk_in;

   pid_wr_sequencer dut (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .host_valid (host_valid),
      .host_sof   (host_sof),
      .host_word  (host_word),
      .host_ready (host_ready),
      .hold_in    (hold_in),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_chan    (wr_chan),
      .wr_data    (wr_data),
      .fifo_count (fifo_count),
      .frame_err  (frame_err),
      .clr_err    (clr_err)
   );

   // Scoreboard monitor
   always @(negedge clk_in) begin
      logic [79:0] exp_e;
      if (wr_en === 1'b1) begin
         n_writes++;
         run_len++;
         if (run_len > max_run) max_run = run_len;
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write got addr=%h chan=%h data=%h, none expected",
                     wr_addr, wr_chan, wr_data);
         end else begin
            exp_e = sb.pop_front();
            if ({wr_addr, wr_chan, wr_data} !== exp_e) begin
               n_fail++;
               $display("FAIL write_content got %h_%h_%h expected %h_%h_%h",
                        wr_addr, wr_chan, wr_data, exp_e[79:64], exp_e[63:48], exp_e[47:0]);
            end
         end
      end else begin
         run_len = 0;
      end
   end

   task automatic send_word(input logic sof, input logic [15:0] w);
      bit ok = 1'b0;
      host_valid = 1'b1;
      host_sof   = sof;
      host_word  = w;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk_in);
         ok = host_ready;
         @(posedge clk_in);
         #1;
      end
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_word_timeout word=%h host_ready stayed %b", w, host_ready);
      end
      host_valid = 1'b0;
      host_sof   = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] a, input logic [15:0] c,
                             input logic [47:0] d, input bit expect_wr);
      if (expect_wr) sb.push_back({a, c, d});
      send_word(1'b1, a);
      send_word(1'b0, c);
      send_word(1'b0, d[47:32]);
      send_word(1'b0, d[31:16]);
      send_word(1'b0, d[15:0]);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic test_reset();
      rst_in = 1'b1; host_valid = 1'b0; host_sof = 1'b0; host_word = '0;
      hold_in = 1'b0; clr_err = 1'b0;
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      n_checks++;
      if ({wr_en, wr_addr, wr_chan, wr_data, fifo_count, frame_err} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got en=%b a=%h c=%h d=%h cnt=%0d err=%b, required all 0",
                  wr_en, wr_addr, wr_chan, wr_data, fifo_count, frame_err);
      end
      n_checks++;
      if (host_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ready got %b required 0", host_ready);
      end
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      @(negedge clk_in);
      n_checks++;
      if (host_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_after_reset got %b required 1", host_ready);
      end
      @(posedge clk_in); #1;
   endtask

   task automatic test_single_frame();
      int w0 = n_writes;
      send_frame(16'h0003, 16'h0002, 48'h1234_5678_9ABC, 1'b1);
      @(negedge clk_in);
      n_checks++;
      if (wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL latency_early got wr_en=%b required 0", wr_en);
      end
      @(negedge clk_in);
      n_checks++;
      if (wr_en !== 1'b1 || wr_addr !== 16'h0003 || wr_data !== 48'h1234_5678_9ABC) begin
         n_fail++;
         $display("FAIL latency_two got en=%b a=%h d=%h required 1/0003/123456789abc",
                  wr_en, wr_addr, wr_data);
      end
      @(negedge clk_in);
      n_checks++;
      if (wr_en !== 1'b0 || wr_addr !== 16'h0003 || wr_chan !== 16'h0002) begin
         n_fail++;
         $display("FAIL hold_last got en=%b a=%h c=%h required 0/0003/0002", wr_en, wr_addr, wr_chan);
      end
      n_checks++;
      if (frame_err !== 1'b0 || n_writes - w0 != 1) begin
         n_fail++;
         $display("FAIL single_summary got err=%b writes=%0d required 0/1", frame_err, n_writes - w0);
      end
      idle(2);
   endtask

   task automatic test_backpressure();
      int w0 = n_writes;
      hold_in = 1'b1;
      for (int i = 0; i < 4; i++)
         send_frame(16'h0010 + 16'(i), 16'(i),
                    {16'hA000 + 16'(i), 16'hB000 + 16'(i), 16'hC000 + 16'(i)}, 1'b1);
      sb.push_back({16'h0014, 16'h0004, 16'hA004, 16'hB004, 16'hC004});
      send_word(1'b1, 16'h0014);
      send_word(1'b0, 16'h0004);
      send_word(1'b0, 16'hA004);
      send_word(1'b0, 16'hB004);
      host_valid = 1'b1; host_sof = 1'b0; host_word = 16'hC004;
      @(negedge clk_in);
      n_checks++;
      if (fifo_count !== 3'd4 || host_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL full_stall got cnt=%0d ready=%b required 4/0", fifo_count, host_ready);
      end
      @(posedge clk_in); #1;
      max_run = 0;
      hold_in = 1'b0;
      send_word(1'b0, 16'hC004);
      idle(8);
      n_checks++;
      if (max_run != 5 || n_writes - w0 != 5) begin
         n_fail++;
         $display("FAIL backpressure_burst got run=%0d writes=%0d required 5/5", max_run, n_writes - w0);
      end
   endtask

   task automatic test_resync();
      int w0 = n_writes;
      send_word(1'b1, 16'h00AA);
      send_word(1'b0, 16'h00BB);
      send_word(1'b0, 16'h1111);
      send_frame(16'h0007, 16'h0001, 48'h0000_0000_0010, 1'b1);
      idle(4);
      n_checks++;
      if (frame_err !== 1'b1 || n_writes - w0 != 1) begin
         n_fail++;
         $display("FAIL resync got err=%b writes=%0d required 1/1", frame_err, n_writes - w0);
      end
      clr_err = 1'b1;
      @(posedge clk_in); #1;
      clr_err = 1'b0;
      @(negedge clk_in);
      n_checks++;
      if (frame_err !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_err got %b required 0", frame_err);
      end
      @(posedge clk_in); #1;
   endtask

   task automatic test_orphan();
      int w0 = n_writes;
      send_word(1'b0, 16'h5555);
      idle(4);
      n_checks++;
      if (frame_err !== 1'b1 || n_writes - w0 != 0 || fifo_count !== 3'd0) begin
         n_fail++;
         $display("FAIL orphan got err=%b writes=%0d cnt=%0d required 1/0/0",
                  frame_err, n_writes - w0, fifo_count);
      end
      // clr_err wins over a same-cycle set
      clr_err = 1'b1;
      send_word(1'b0, 16'h6666);
      clr_err = 1'b0;
      @(negedge clk_in);
      n_checks++;
      if (frame_err !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_priority got %b required 0", frame_err);
      end
      @(posedge clk_in); #1;
   endtask

   task automatic test_reset_mid();
      int w0;
      hold_in = 1'b1;
      send_frame(16'h0021, 16'h0003, 48'hDEAD_BEEF_0001, 1'b0);
      send_frame(16'h0022, 16'h0004, 48'hDEAD_BEEF_0002, 1'b0);
      send_word(1'b1, 16'h0023);
      @(negedge clk_in);
      n_checks++;
      if (fifo_count !== 3'd2) begin
         n_fail++;
         $display("FAIL queued_two got %0d required 2", fifo_count);
      end
      @(posedge clk_in); #1;
      rst_in = 1'b1;
      @(negedge clk_in);
      n_checks++;
      if (host_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_in_reset got %b required 0", host_ready);
      end
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      hold_in = 1'b0;
      w0 = n_writes;
      @(negedge clk_in);
      n_checks++;
      if ({wr_en, wr_addr, wr_chan, wr_data, fifo_count} !== '0 || host_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_outputs got en=%b a=%h c=%h d=%h cnt=%0d ready=%b",
                  wr_en, wr_addr, wr_chan, wr_data, fifo_count, host_ready);
      end
      idle(6);
      n_checks++;
      if (n_writes - w0 != 0 || fifo_count !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_mid_writes got writes=%0d cnt=%0d required 0/0", n_writes - w0, fifo_count);
      end
      // the partial frame must be gone: a non-sof word now is an orphan
      send_word(1'b0, 16'h0001);
      @(negedge clk_in);
      n_checks++;
      if (frame_err !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_drops_partial got err=%b required 1", frame_err);
      end
      @(posedge clk_in); #1;
      clr_err = 1'b1;
      @(posedge clk_in); #1;
      clr_err = 1'b0;
   endtask

   task automatic test_push_pop_same_cycle();
      int w0 = n_writes;
      hold_in = 1'b1;
      send_frame(16'h0031, 16'h0005, 48'h0102_0304_0506, 1'b1);
      sb.push_back({16'h0032, 16'h0006, 48'h0A0B_0C0D_0E0F});
      send_word(1'b1, 16'h0032);
      send_word(1'b0, 16'h0006);
      send_word(1'b0, 16'h0A0B);
      send_word(1'b0, 16'h0C0D);
      hold_in = 1'b0;
      send_word(1'b0, 16'h0E0F);
      @(negedge clk_in);
      n_checks++;
      if (fifo_count !== 3'd1 || wr_en !== 1'b1) begin
         n_fail++;
         $display("FAIL push_pop_count got cnt=%0d en=%b required 1/1", fifo_count, wr_en);
      end
      idle(5);
      n_checks++;
      if (n_writes - w0 != 2 || fifo_count !== 3'd0) begin
         n_fail++;
         $display("FAIL push_pop_writes got writes=%0d cnt=%0d required 2/0", n_writes - w0, fifo_count);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_backpressure();
      test_resync();
      test_orphan();
      test_reset_mid();
      test_push_pop_same_cycle();
      idle(4);
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pid_wr_sequencer.md
# pid_wr_sequencer

Host-side initiator for the PID pipeline configuration write bus. It receives a stream of 16-bit host words, assembles them into framed write commands (address, channel, 48-bit data) and buffers them in a 4-deep FIFO. It issues single-cycle `wr_en` transactions to the pipeline stages (instruction dispatch, oversample filter, PID filter, output filter). It sits between the host interface logic and `pid_pipeline`, and is the producer end of the `wr_en/wr_addr/wr_chan/wr_data` interface that those stages consume.

## Interface
- `W_HOST`, 16, host word width; fixed at 16.
- `W_WR_ADDR`, 16, write address width; must equal `W_HOST`.
- `W_WR_CHAN`, 16, write channel width; must equal `W_HOST`.
- `W_WR_DATA`, 48, write data width; must be a multiple of `W_HOST`; `N_DW = W_WR_DATA/W_HOST` (default 3).
- `FIFO_DEPTH`, 4, command FIFO depth; power of two.

Ports:
- `clk_in` in 1 — single clock.
- `rst_in` in 1 — synchronous, active-high reset.
- `host_valid` in 1 — host word valid.
- `host_sof` in 1 — start-of-frame marker; qualified by `host_valid`.
- `host_word` in `W_HOST` — host word.
- `host_ready` out 1 — word accepted on a cycle where `host_valid && host_ready`.
- `hold_in` in 1 — while high, no write is issued (pipeline busy).
- `wr_en` out 1 — one-cycle write strobe.
- `wr_addr` out `W_WR_ADDR` — write address.
- `wr_chan` out `W_WR_CHAN` — write channel.
- `wr_data` out `W_WR_DATA` — write data.
- `fifo_count` out `log2(FIFO_DEPTH)+1` — pending commands.
- `frame_err` out 1 — sticky flag, set on a framing error.
- `clr_err` in 1 — clears `frame_err`.

## Operation
- Assembler FSM states: `S_ADDR`, `S_CHAN`, `S_DATA`. A data-word counter `dw_cnt` runs from 0 to `N_DW-1`.
- All transitions below occur on an accepted word only.
  - `S_ADDR`: word becomes the address; go to `S_CHAN`.
  - `S_CHAN`: word becomes the channel; go to `S_DATA` with `dw_cnt=0`.
  - `S_DATA`: word is loaded MSW first (word 0 → `data[47:32]`). When `dw_cnt==N_DW-1`, push `{addr,chan,data}` into the FIFO and return to `S_ADDR`.
- `host_sof`:
  - An accepted word with `host_sof=1` always starts a new frame and is taken as the address.
  - If the FSM was not in `S_ADDR`, the partial frame is discarded and `frame_err` is set.
  - A word in `S_ADDR` with `host_sof=0` is dropped, and `frame_err` is set.
- `host_ready = !rst_in && !(state==S_DATA && dw_cnt==N_DW-1 && fifo_full)`. The same-cycle pop is not considered, so a push into a full FIFO never occurs.
- Issue: when the FIFO is non-empty and `hold_in==0`, pop one entry. On the next edge, register the entry onto `wr_addr/chan/data` and assert `wr_en` for one cycle. At most one write per cycle; back-to-back writes are allowed.
- `wr_addr/chan/data` hold their last issued values while `wr_en==0`.
- A simultaneous push and pop leaves `fifo_count` unchanged.
- `frame_err`: `clr_err` takes priority over a same-cycle set.

## Timing
- Reset values:
  - `wr_en=0`, `wr_addr/chan/data=0`, `fifo_count=0`, `frame_err=0`.
  - `host_ready=0` while `rst_in` is high, and 1 on the first cycle after.
  - FSM returns to `S_ADDR`.
- Latency:
  - Last data word accepted at edge N → FIFO non-empty after N.
  - Pop at edge N+1 → `wr_en` high for cycle N+1..N+2.
  - Total: 2 cycles, with `hold_in` low.
- `hold_in` is sampled on the pop cycle. A write already registered completes regardless of a later `hold_in` rise.
- Reset mid-frame or mid-issue discards the partial frame and all FIFO contents. No `wr_en` is produced after the reset edge.

## Structure
- Shared package `pid_wr_pkg` holds:
  - FSM state encoding;
  - `N_DW`;
  - FIFO entry width (`W_WR_ADDR+W_WR_CHAN+W_WR_DATA` = 80);
  - field offsets within the entry.
- Sub-module `sync_fifo`: parameterized width/depth, single clock, synchronous reset, `full/empty/count` outputs.
- The assembler FSM and issue register live in the top module.

## Test plan
- Single frame: sof+`0x0003`, `0x0002`, `0x1234`, `0x5678`, `0x9ABC` → one `wr_en` 2 cycles after the last word, with `wr_addr=0x0003`, `wr_chan=0x0002`, `wr_data=0x123456789ABC`; `frame_err=0`.
- Backpressure: `hold_in=1`, send 5 frames → `fifo_count=4` and `host_ready` low on the 5th frame's last word. Release `hold_in` → 5 consecutive `wr_en` cycles in frame order.
- Resync: sof frame aborted after 3 words by a new sof frame `0x0007`,`0x0001`,`0`,`0`,`0x0010` → exactly one write (addr 7, data `0x10`), `frame_err=1`. Then `clr_err` → 0.
- Orphan word: word without sof in `S_ADDR` → dropped, `frame_err=1`, no write.
- Reset mid-operation: 2 frames queued under hold, `rst_in` pulsed, hold released → no `wr_en`, `fifo_count=0`, outputs 0.
- Same-cycle push/pop: `fifo_count=1` while a new frame completes with `hold_in=0` → count stays 1, writes issued in order.
